// File: rtl/instr_exec_unit.sv
// Execution stage behind the instruction register: walks a block of stored
// instructions, computes a signed result for each and hands it out over valid/ready.
module instr_exec_unit #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned OP_W        = 32,
    parameter int unsigned DIV_LATENCY = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   first_ptr,
    input  logic [ADDR_W:0]     count,
    output logic [ADDR_W-1:0]   read_pointer,
    input  logic [3:0]          opcode,
    input  logic [OP_W-1:0]     operand_a,
    input  logic [OP_W-1:0]     operand_b,
    output logic [2*OP_W-1:0]   result,
    output logic [ADDR_W-1:0]   result_ptr,
    output logic                div_by_zero,
    output logic                illegal_op,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                busy,
    output logic                done
);

    localparam int unsigned RES_W = 2 * OP_W;
    localparam int unsigned CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

    localparam logic [3:0] OP_ZERO  = 4'd0;
    localparam logic [3:0] OP_PASSA = 4'd1;
    localparam logic [3:0] OP_PASSB = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_MULT  = 4'd5;
    localparam logic [3:0] OP_DIV   = 4'd6;
    localparam logic [3:0] OP_MOD   = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT,
        S_OUT
    } state_t;

    state_t              state;
    logic [ADDR_W:0]     remaining;
    logic [CNT_W-1:0]    wait_cnt;
    logic [3:0]          hold_op;
    logic [OP_W-1:0]     hold_a;
    logic [OP_W-1:0]     hold_b;

    logic [3:0]              sel_op;
    logic [OP_W-1:0]         sel_a;
    logic [OP_W-1:0]         sel_b;
    logic signed [RES_W-1:0] ext_a;
    logic signed [RES_W-1:0] ext_b;
    logic signed [RES_W-1:0] calc_res;
    logic                    calc_dbz;
    logic                    calc_ill;
    logic                    is_div;

    // Live operands in EXEC; held copies while a divide sits in WAIT.
    always_comb begin
        sel_op = hold_op;
        sel_a  = hold_a;
        sel_b  = hold_b;
        if (state == S_EXEC) begin
            sel_op = opcode;
            sel_a  = operand_a;
            sel_b  = operand_b;
        end
    end

    assign ext_a  = RES_W'($signed(sel_a));
    assign ext_b  = RES_W'($signed(sel_b));
    assign is_div = (sel_op == OP_DIV) || (sel_op == OP_MOD);

    // Arithmetic; SV signed / and % already truncate toward zero.
    always_comb begin
        calc_res = '0;
        calc_dbz = 1'b0;
        calc_ill = 1'b0;
        case (sel_op)
            OP_ZERO:  calc_res = '0;
            OP_PASSA: calc_res = ext_a;
            OP_PASSB: calc_res = ext_b;
            OP_ADD:   calc_res = ext_a + ext_b;
            OP_SUB:   calc_res = ext_a - ext_b;
            OP_MULT:  calc_res = ext_a * ext_b;
            OP_DIV: begin
                if (ext_b == '0) calc_dbz = 1'b1;
                else             calc_res = ext_a / ext_b;
            end
            OP_MOD: begin
                if (ext_b == '0) calc_dbz = 1'b1;
                else             calc_res = ext_a % ext_b;
            end
            default:  calc_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            read_pointer <= '0;
            remaining    <= '0;
            wait_cnt     <= '0;
            hold_op      <= '0;
            hold_a       <= '0;
            hold_b       <= '0;
            result       <= '0;
            result_ptr   <= '0;
            div_by_zero  <= 1'b0;
            illegal_op   <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            read_pointer <= first_ptr;
                            remaining    <= count;
                            busy         <= 1'b1;
                            state        <= S_FETCH;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_FETCH: state <= S_EXEC;
                S_EXEC: begin
                    hold_op <= opcode;
                    hold_a  <= operand_a;
                    hold_b  <= operand_b;
                    if (is_div) begin
                        wait_cnt <= CNT_W'(DIV_LATENCY - 1);
                        state    <= S_WAIT;
                    end else begin
                        result       <= calc_res;
                        result_ptr   <= read_pointer;
                        div_by_zero  <= calc_dbz;
                        illegal_op   <= calc_ill;
                        result_valid <= 1'b1;
                        state        <= S_OUT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        result       <= calc_res;
                        result_ptr   <= read_pointer;
                        div_by_zero  <= calc_dbz;
                        illegal_op   <= calc_ill;
                        result_valid <= 1'b1;
                        state        <= S_OUT;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_OUT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        remaining    <= remaining - 1'b1;
                        if (remaining > (ADDR_W + 1)'(1)) begin
                            read_pointer <= read_pointer + 1'b1;
                            state        <= S_FETCH;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Scoreboard bench for instr_exec_unit: a longint reference model predicts every
// result, pointer, flag and latency; a negedge monitor checks what the DUT presents.
module tb_instr_exec_unit;

    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned OP_W        = 32;
    localparam int unsigned DIV_LATENCY = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] first_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] read_pointer;
    logic [3:0]        opcode;
    logic [OP_W-1:0]   operand_a;
    logic [OP_W-1:0]   operand_b;
    logic [2*OP_W-1:0] result;
    logic [ADDR_W-1:0] result_ptr;
    logic              div_by_zero;
    logic              illegal_op;
    logic              result_valid;
    logic              result_ready;
    logic              busy;
    logic              done;

    instr_exec_unit #(.ADDR_W(ADDR_W), .OP_W(OP_W), .DIV_LATENCY(DIV_LATENCY)) dut (
        .clk(clk), .reset(reset), .start(start), .first_ptr(first_ptr), .count(count),
        .read_pointer(read_pointer), .opcode(opcode), .operand_a(operand_a),
        .operand_b(operand_b), .result(result), .result_ptr(result_ptr),
        .div_by_zero(div_by_zero), .illegal_op(illegal_op), .result_valid(result_valid),
        .result_ready(result_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Instruction register contents, read combinationally by address.
    logic [3:0]  mem_op [32];
    logic [31:0] mem_a  [32];
    logic [31:0] mem_b  [32];
    assign opcode    = mem_op[read_pointer];
    assign operand_a = mem_a[read_pointer];
    assign operand_b = mem_b[read_pointer];

    typedef struct {
        logic [63:0] res;
        logic [4:0]  ptr;
        logic        dbz;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   passes   = 0;
    int   done_cnt = 0;
    int   cyc      = 0;
    int   ready_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input int idx);
        exp_t   e;
        longint a;
        longint b;
        a     = longint'($signed(mem_a[idx]));
        b     = longint'($signed(mem_b[idx]));
        e.res = '0;
        e.dbz = 1'b0;
        e.ill = 1'b0;
        e.ptr = 5'(idx);
        e.lat = 2;
        case (mem_op[idx])
            4'd0: e.res = '0;
            4'd1: e.res = a;
            4'd2: e.res = b;
            4'd3: e.res = a + b;
            4'd4: e.res = a - b;
            4'd5: e.res = a * b;
            4'd6, 4'd7: begin
                e.lat = 2 + int'(DIV_LATENCY);
                if (b == 0)                e.dbz = 1'b1;
                else if (mem_op[idx] == 6) e.res = a / b;
                else                       e.res = a % b;
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic set_mem(input int idx, input int op, input int a, input int b);
        mem_op[idx] = 4'(op);
        mem_a[idx]  = 32'(a);
        mem_b[idx]  = 32'(b);
    endtask

    task automatic start_block(input int first, input int cnt);
        for (int i = 0; i < cnt; i++) exp_q.push_back(model((first + i) % 32));
        first_ptr = 5'(first);
        count     = 6'(cnt);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        bit seen = 1'b0;
        for (int c = 0; c < 4000 && !seen; c++) begin
            if (done) seen = 1'b1;
            else tick();
        end
        check("done_seen", 64'(seen), 64'(1));
        tick();
        check("done_pulses", 64'(done_cnt - d0), 64'(1));
        check("busy_after_done", 64'(busy), 64'(0));
        check("queue_drained", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic run_block(input int first, input int cnt);
        int d0 = done_cnt;
        start_block(first, cnt);
        wait_done(d0);
    endtask

    task automatic wait_valid();
        bit seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (result_valid) seen = 1'b1;
            else tick();
        end
        check("valid_seen", 64'(seen), 64'(1));
    endtask

    // Consumer: ready held low, held high, or random per cycle.
    initial begin
        result_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       result_ready = 1'b0;
                1:       result_ready = 1'b1;
                default: result_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: latency from each launch edge (start or accept) to valid rise, and accepted payloads.
    initial begin
        int   launch = 0;
        bit   pv     = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 1'b0;
            end else begin
                if (start && !busy) launch = cyc + 1;
                if (result_valid && !pv) begin
                    if (exp_q.size() == 0) check("spurious_valid", 64'(1), 64'(0));
                    else begin
                        check("latency", 64'(cyc - launch), 64'(exp_q[0].lat));
                        check("read_pointer", 64'(read_pointer), 64'(exp_q[0].ptr));
                    end
                end
                if (result_valid && result_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("result", result, e.res);
                    check("result_ptr", 64'(result_ptr), 64'(e.ptr));
                    check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                    check("illegal_op", 64'(illegal_op), 64'(e.ill));
                    launch = cyc + 1;
                end
                pv = result_valid;
                if (done) begin
                    done_cnt++;
                    check("done_with_busy", 64'(busy), 64'(0));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int first;
        int cnt;
        int r;
        reset     = 1'b1;
        start     = 1'b0;
        first_ptr = '0;
        count     = '0;
        for (int i = 0; i < 32; i++) set_mem(i, 0, 0, 0);
        repeat (3) tick();
        check("reset_result", result, 64'(0));
        check("reset_ctl", 64'({read_pointer, result_ptr, div_by_zero, illegal_op,
                                result_valid, busy, done}), 64'(0));
        reset = 1'b0;
        tick();

        // Reset while a result is held in OUT.
        set_mem(0, 1, 77, 0);
        set_mem(1, 3, 1, 2);
        ready_mode = 0;
        d0 = done_cnt;
        start_block(0, 2);
        wait_valid();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_result", result, 64'(0));
        check("async_reset_ctl", 64'({read_pointer, result_ptr, div_by_zero, illegal_op,
                                      result_valid, busy, done}), 64'(0));
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("no_done_after_reset", 64'(done_cnt - d0), 64'(0));
        set_mem(0, 3, 5, -7);
        ready_mode = 1;
        run_block(0, 1);

        // Mixed ALU block.
        set_mem(3, 3, 5, -7);
        set_mem(4, 4, -3, 10);
        set_mem(5, 5, -65536, 65536);
        set_mem(6, 2, 0, 42);
        run_block(3, 4);

        // Divider path, including divide-by-zero and MIN/-1.
        set_mem(8, 6, -7, 2);
        set_mem(9, 7, -7, 2);
        set_mem(10, 6, 9, 0);
        set_mem(11, 6, 32'h8000_0000, -1);
        set_mem(12, 7, 9, 0);
        run_block(8, 5);

        // Pointer wrap 31 -> 0.
        set_mem(30, 1, 30, 0);
        set_mem(31, 1, 31, 0);
        set_mem(0, 1, 100, 0);
        set_mem(1, 2, 0, -1);
        run_block(30, 4);

        // Empty block.
        d0 = done_cnt;
        first_ptr = 5'd7;
        count     = '0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("empty_done", 64'(done), 64'(1));
        check("empty_busy", 64'(busy), 64'(0));
        check("empty_valid", 64'(result_valid), 64'(0));
        tick();
        check("empty_done_once", 64'(done_cnt - d0), 64'(1));
        check("empty_done_clear", 64'(done), 64'(0));

        // Stall on an illegal-op result; a start during the stall is ignored.
        set_mem(14, 12, 99, 5);
        set_mem(15, 4, 1000, 1);
        ready_mode = 0;
        d0 = done_cnt;
        start_block(14, 2);
        wait_valid();
        for (int k = 0; k < 10; k++) begin
            if (k == 4) begin
                first_ptr = 5'd20;
                count     = 6'd3;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            check("stall_result", result, exp_q[0].res);
            check("stall_flags", 64'({illegal_op, div_by_zero}), 64'({exp_q[0].ill, exp_q[0].dbz}));
            check("stall_rptr", 64'(result_ptr), 64'(exp_q[0].ptr));
            check("stall_read_pointer", 64'(read_pointer), 64'(exp_q[0].ptr));
            tick();
        end
        start      = 1'b0;
        ready_mode = 1;
        wait_done(d0);

        // Randomized blocks with random back-pressure.
        ready_mode = 2;
        for (int blk = 0; blk < 20; blk++) begin
            first = $urandom_range(0, 31);
            cnt   = $urandom_range(1, 6);
            for (int i = 0; i < cnt; i++) begin
                r = $urandom_range(0, 7);
                set_mem((first + i) % 32, $urandom_range(0, 15),
                        (r == 0) ? 32'h8000_0000 : (r == 1) ? -1 : int'($urandom),
                        (r == 2) ? 0 : (r == 3) ? -1 : (r == 4) ? $urandom_range(1, 9) : int'($urandom));
            end
            run_block(first, cnt);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/instr_exec_unit.md
Name: instr_exec_unit

Overview:
- Execution stage directly downstream of the instruction register.
- On `start`, walks `read_pointer` over a block of stored instructions.
- For each instruction it samples the returned opcode and operands, computes a signed result, and presents it on a valid/ready output handshake.
- Pulses `done` when the block is finished; flags divide-by-zero per result.

Parameters:
- ADDR_W, 5, read pointer width (32-entry register file)
- OP_W, 32, signed operand width
- DIV_LATENCY, 4, extra cycles spent in WAIT for DIV/MOD (>=1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  reset, asynchronous active-high
- start  in  1  begin a block; sampled in IDLE only
- first_ptr  in  ADDR_W  first register-file address to execute
- count  in  ADDR_W+1  number of instructions, 0..32
- read_pointer  out  ADDR_W  address driven to the instruction register (registered)
- opcode  in  4  opcode returned for read_pointer: ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7; 8..15 illegal
- operand_a  in  OP_W  signed operand A returned for read_pointer
- operand_b  in  OP_W  signed operand B returned for read_pointer
- result  out  2*OP_W  signed result, stable while result_valid=1
- result_ptr  out  ADDR_W  address the current result came from
- div_by_zero  out  1  qualifies result: DIV/MOD with operand_b=0
- illegal_op  out  1  qualifies result: opcode 8..15
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after the last result is accepted

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - read_pointer, result, result_ptr, remaining count and WAIT counter = 0.
  - div_by_zero, illegal_op, result_valid, busy, done = 0.
- States: IDLE, FETCH, EXEC, WAIT, OUT.
- IDLE:
  - start=1 and count!=0 -> latch first_ptr into read_pointer and count into remaining; go to FETCH.
  - start=1 and count=0 -> done=1 next cycle, stay IDLE.
  - start is ignored outside IDLE.
- FETCH: one cycle for the register-file read to settle; go to EXEC.
- EXEC: sample opcode/operands at this edge; compute.
  - DIV/MOD -> load WAIT counter with DIV_LATENCY-1, go to WAIT.
  - Any other opcode -> register result and flags, result_valid=1, go to OUT.
- WAIT: decrement the counter each cycle. At 0, register result, set result_valid=1, go to OUT.
- OUT: hold result, result_ptr and flags stable until result_valid && result_ready on a clock edge. On acceptance:
  - result_valid=0 and remaining decrements.
  - remaining was >1 -> read_pointer increments (wraps 31->0), go to FETCH.
  - remaining was 1 -> done=1 for one cycle, go to IDLE.
- Latency (start edge = E0): result_valid visible after E2 for non-DIV/MOD; after E2+DIV_LATENCY for DIV/MOD. With result_ready held high, throughput is one result per 3 cycles (non-div).
- Arithmetic (all 2*OP_W signed, operands sign-extended):
  - ZERO -> 0; PASSA -> a; PASSB -> b.
  - ADD -> a+b; SUB -> a-b; MULT -> full a*b product.
  - DIV -> quotient truncated toward zero. MIN/-1 yields +2^31 with no overflow.
  - MOD -> remainder with the sign of the dividend.
  - operand_b=0 for DIV/MOD -> result=0, div_by_zero=1.
  - Illegal opcode -> result=0, illegal_op=1.
- Flags and result_ptr update together with result; both flags clear on the next computed result.
- busy=1 from the edge after start through the edge that asserts done; done and busy are never high together.
- Reset asserted mid-block abandons remaining instructions; no done pulse.

Test Plan:
- Reset during OUT holding a result -> all outputs 0 immediately (async), state IDLE; a following start with first_ptr=0, count=1 (ADD, a=5, b=-7) behaves normally.
- start, first_ptr=3, count=4; entries ADD(5,-7), SUB(-3,10), MULT(-65536,65536), PASSB(0,42) -> results -2, -13, -4294967296, 42; result_ptr 3,4,5,6; done pulses once after 4th accept.
- DIV(-7,2), MOD(-7,2), DIV(9,0) with DIV_LATENCY=4 -> results -3, -1, 0 with div_by_zero only on the third; each result_valid rises exactly 6 cycles after its FETCH entry.
- first_ptr=30, count=4 -> read_pointer sequence 30,31,0,1; count=0 -> done pulse one cycle later, busy stays 0, no result_valid.
- Hold result_ready=0 for 10 cycles during OUT -> result, result_ptr, flags unchanged, read_pointer frozen; a start pulse during the stall is ignored; opcode 12 entry -> result 0, illegal_op=1.
